// File: rtl/hmac_seq_pkg.sv
// Shared types and block geometry for the HMAC block sequencer.
package hmac_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_PADX,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } seq_state_e;

    localparam int          BLOCK_WORDS = 32;
    localparam int          BLOCK_BYTES = 128;
    localparam int          LEN_OFFSET  = 112;
    localparam logic [7:0]  PAD_BYTE    = 8'h80;
    localparam logic [63:0] IPAD_BITS   = 64'd1024;

    // Message length in bits including the inner key block that precedes it.
    function automatic logic [63:0] length_bits(input logic [63:0] nbytes);
        return IPAD_BITS + (nbytes << 3);
    endfunction

endpackage

// File: rtl/hmac_block_assembler.sv
// 1024-bit block register with word write, pad byte insert, length insert and clear.
module hmac_block_assembler
    import hmac_seq_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          wr_en,
    input  logic [4:0]    wr_idx,
    input  logic [31:0]   wr_data,
    input  logic [2:0]    wr_lanes,
    input  logic          pad_en,
    input  logic [6:0]    pad_pos,
    input  logic          len_en,
    input  logic [63:0]   len_val,
    output logic [1023:0] block
);

    // Element k holds block byte 127-k, so block byte b lives in element ~b
    // and byte 0 ends up in [1023:1016].
    logic [127:0][7:0] bytes_q;
    logic [127:0][7:0] bytes_d;
    logic [6:0]        lane_pos;

    // Compose the next block: clear first, then the word, then pad byte, then length.
    always_comb begin
        bytes_d  = clear ? '0 : bytes_q;
        lane_pos = '0;
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                lane_pos = {wr_idx, 2'(i)};
                bytes_d[~lane_pos] = (3'(i) < wr_lanes) ? wr_data[8*(3-i) +: 8] : 8'h00;
            end
        end
        if (pad_en) begin
            bytes_d[~pad_pos] = PAD_BYTE;
        end
        if (len_en) begin
            bytes_d[15:0] = {64'd0, len_val};
        end
    end

    // Block register.
    always_ff @(posedge clk) begin
        if (reset) begin
            bytes_q <= '0;
        end else begin
            bytes_q <= bytes_d;
        end
    end

    assign block = bytes_q;

endmodule

// File: rtl/hmac_block_sequencer.sv
// Packs a byte-granular message into padded 1024-bit blocks and drives the HMAC core.
module hmac_block_sequencer
    import hmac_seq_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          zeroize,
    input  logic          start,
    input  logic          mode,
    input  logic          msg_valid,
    output logic          msg_ready,
    input  logic [31:0]   msg_data,
    input  logic          msg_last,
    input  logic [1:0]    msg_last_bytes,
    output logic          core_init_cmd,
    output logic          core_next_cmd,
    output logic          core_mode_cmd,
    output logic [1023:0] core_block_msg,
    input  logic          core_ready,
    input  logic          core_tag_valid,
    input  logic [511:0]  core_tag,
    output logic          busy,
    output logic          tag_valid,
    output logic [511:0]  tag
);

    logic          abort;
    seq_state_e    state_q, state_d;
    logic [4:0]    widx_q, widx_d;
    logic [63:0]   nbytes_q, nbytes_d;
    logic          mode_q, mode_d;
    logic          first_q, first_d;
    logic          final_q, final_d;
    logic          padx_q, padx_d;
    logic          pad80_q, pad80_d;
    logic          settle_q, settle_d;
    logic          init_q, init_d;
    logic          next_q, next_d;
    logic          tag_valid_q, tag_valid_d;
    logic [511:0]  tag_q, tag_d;

    logic          asm_clear;
    logic          asm_wr;
    logic          asm_pad;
    logic [6:0]    asm_pad_pos;
    logic          asm_len;
    logic [63:0]   asm_len_val;
    logic [2:0]    lanes;
    logic [63:0]   nbytes_acc;
    logic [7:0]    off;

    assign abort = reset | zeroize;

    hmac_block_assembler u_asm (
        .clk      (clk),
        .reset    (abort),
        .clear    (asm_clear),
        .wr_en    (asm_wr),
        .wr_idx   (widx_q),
        .wr_data  (msg_data),
        .wr_lanes (lanes),
        .pad_en   (asm_pad),
        .pad_pos  (asm_pad_pos),
        .len_en   (asm_len),
        .len_val  (asm_len_val),
        .block    (core_block_msg)
    );

    // Next-state, bookkeeping and block-edit controls for the sequencer.
    always_comb begin
        state_d     = state_q;
        widx_d      = widx_q;
        nbytes_d    = nbytes_q;
        mode_d      = mode_q;
        first_d     = first_q;
        final_d     = final_q;
        padx_d      = padx_q;
        pad80_d     = pad80_q;
        settle_d    = settle_q;
        init_d      = 1'b0;
        next_d      = 1'b0;
        tag_valid_d = tag_valid_q;
        tag_d       = tag_q;
        asm_clear   = 1'b0;
        asm_wr      = 1'b0;
        asm_pad     = 1'b0;
        asm_pad_pos = '0;
        asm_len     = 1'b0;
        asm_len_val = '0;
        msg_ready   = (state_q == ST_FILL);
        lanes       = (msg_last && (msg_last_bytes != 2'd0)) ? {1'b0, msg_last_bytes} : 3'd4;
        nbytes_acc  = nbytes_q + {61'd0, lanes};
        off         = {1'b0, widx_q, 2'b00} + {5'd0, lanes};

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    asm_clear   = 1'b1;
                    widx_d      = '0;
                    nbytes_d    = '0;
                    tag_valid_d = 1'b0;
                    tag_d       = '0;
                    mode_d      = mode;
                    first_d     = 1'b1;
                    final_d     = 1'b0;
                    padx_d      = 1'b0;
                    pad80_d     = 1'b0;
                    state_d     = ST_FILL;
                end
            end
            ST_FILL: begin
                if (msg_valid) begin
                    asm_wr   = 1'b1;
                    widx_d   = widx_q + 5'd1;
                    nbytes_d = nbytes_acc;
                    if (msg_last) begin
                        // Where the pad byte lands decides whether the length still fits.
                        if (off < 8'(LEN_OFFSET)) begin
                            asm_pad     = 1'b1;
                            asm_pad_pos = off[6:0];
                            asm_len     = 1'b1;
                            asm_len_val = length_bits(nbytes_acc);
                            final_d     = 1'b1;
                        end else if (off < 8'(BLOCK_BYTES)) begin
                            asm_pad     = 1'b1;
                            asm_pad_pos = off[6:0];
                            final_d     = 1'b0;
                            padx_d      = 1'b1;
                            pad80_d     = 1'b0;
                        end else begin
                            final_d     = 1'b0;
                            padx_d      = 1'b1;
                            pad80_d     = 1'b1;
                        end
                        state_d = ST_ISSUE;
                    end else if (widx_q == 5'(BLOCK_WORDS - 1)) begin
                        final_d = 1'b0;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_PADX: begin
                asm_clear   = 1'b1;
                asm_pad     = pad80_q;
                asm_pad_pos = '0;
                asm_len     = 1'b1;
                asm_len_val = length_bits(nbytes_q);
                padx_d      = 1'b0;
                final_d     = 1'b1;
                state_d     = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (core_ready) begin
                    init_d   = first_q;
                    next_d   = ~first_q;
                    first_d  = 1'b0;
                    settle_d = 1'b1;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // The core still shows ready while it registers the command.
                if (settle_q) begin
                    settle_d = 1'b0;
                end else if (core_ready) begin
                    if (final_q) begin
                        if (core_tag_valid) begin
                            tag_d = mode_q ? core_tag : {core_tag[511:128], 128'd0};
                        end
                        state_d = ST_DONE;
                    end else if (padx_q) begin
                        state_d = ST_PADX;
                    end else begin
                        asm_clear = 1'b1;
                        widx_d    = '0;
                        state_d   = ST_FILL;
                    end
                end
            end
            ST_DONE: begin
                tag_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and bookkeeping registers; reset and zeroize both abort to IDLE.
    always_ff @(posedge clk) begin
        if (abort) begin
            state_q     <= ST_IDLE;
            widx_q      <= '0;
            nbytes_q    <= '0;
            mode_q      <= 1'b0;
            first_q     <= 1'b0;
            final_q     <= 1'b0;
            padx_q      <= 1'b0;
            pad80_q     <= 1'b0;
            settle_q    <= 1'b0;
            init_q      <= 1'b0;
            next_q      <= 1'b0;
            tag_valid_q <= 1'b0;
            tag_q       <= '0;
        end else begin
            state_q     <= state_d;
            widx_q      <= widx_d;
            nbytes_q    <= nbytes_d;
            mode_q      <= mode_d;
            first_q     <= first_d;
            final_q     <= final_d;
            padx_q      <= padx_d;
            pad80_q     <= pad80_d;
            settle_q    <= settle_d;
            init_q      <= init_d;
            next_q      <= next_d;
            tag_valid_q <= tag_valid_d;
            tag_q       <= tag_d;
        end
    end

    // A pulse already on the wires is suppressed in the cycle an abort arrives.
    assign core_init_cmd = init_q & ~abort;
    assign core_next_cmd = next_q & ~abort;
    assign core_mode_cmd = mode_q;
    assign busy          = (state_q != ST_IDLE);
    assign tag_valid     = tag_valid_q;
    assign tag           = tag_q;

endmodule

// File: tb/tb_hmac_block_sequencer.sv
// Self-checking bench: padding model + scoreboard of expected core commands.
module tb_hmac_block_sequencer;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          zeroize = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic          msg_valid = 1'b0;
    logic          msg_ready;
    logic [31:0]   msg_data = '0;
    logic          msg_last = 1'b0;
    logic [1:0]    msg_last_bytes = '0;
    logic          core_init_cmd;
    logic          core_next_cmd;
    logic          core_mode_cmd;
    logic [1023:0] core_block_msg;
    logic          core_ready;
    logic          core_tag_valid = 1'b0;
    logic [511:0]  core_tag;
    logic          busy;
    logic          tag_valid;
    logic [511:0]  tag;

    typedef struct {
        logic [1023:0] blk;
        bit            is_init;
        bit            mode;
    } sb_item_t;

    typedef struct {
        int len;
        bit md;
        int blocks;
    } vec_t;

    int           total = 0;
    int           bad = 0;
    int           blocks_seen = 0;
    int           busy_cnt = 0;
    bit           rdy_m = 1'b1;
    bit           hold = 1'b0;
    logic [7:0]   msg [0:511];
    logic [511:0] tag_in = '0;
    sb_item_t     exp_q [$];
    sb_item_t     mdl_it;
    vec_t         vecs [8];

    assign core_ready = rdy_m & ~hold;
    assign core_tag   = tag_in;

    hmac_block_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .zeroize        (zeroize),
        .start          (start),
        .mode           (mode),
        .msg_valid      (msg_valid),
        .msg_ready      (msg_ready),
        .msg_data       (msg_data),
        .msg_last       (msg_last),
        .msg_last_bytes (msg_last_bytes),
        .core_init_cmd  (core_init_cmd),
        .core_next_cmd  (core_next_cmd),
        .core_mode_cmd  (core_mode_cmd),
        .core_block_msg (core_block_msg),
        .core_ready     (core_ready),
        .core_tag_valid (core_tag_valid),
        .core_tag       (core_tag),
        .busy           (busy),
        .tag_valid      (tag_valid),
        .tag            (tag)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference SHA-512 padding: msg || 0x80 || zeros || 128-bit length, length counts the key block.
    task automatic push_expected(input int n, input bit md);
        logic [7:0]  pb [0:383];
        logic [63:0] len;
        int          total_b;
        sb_item_t    it;
        total_b = ((n + 17 + 127) / 128) * 128;
        for (int i = 0; i < 384; i++) pb[i] = (i < n) ? msg[i] : 8'h00;
        pb[n] = 8'h80;
        len = 64'd1024 + 64'(n) * 64'd8;
        for (int j = 0; j < 8; j++) pb[total_b - 1 - j] = len[8*j +: 8];
        for (int b = 0; b < total_b / 128; b++) begin
            for (int k = 0; k < 128; k++) it.blk[1023 - 8*k -: 8] = pb[b*128 + k];
            it.is_init = (b == 0);
            it.mode    = md;
            exp_q.push_back(it);
        end
    endtask

    // Core model: checks each command against the scoreboard, then stays busy for a few cycles.
    always @(negedge clk) begin
        if (reset || zeroize) begin
            rdy_m    = 1'b1;
            busy_cnt = 0;
        end else if (core_init_cmd || core_next_cmd) begin
            blocks_seen++;
            check_output("cmd_expected", 512'(exp_q.size() != 0), 512'd1);
            if (exp_q.size() != 0) begin
                mdl_it = exp_q.pop_front();
                check_output("cmd_kind", 512'({core_init_cmd, core_next_cmd}), mdl_it.is_init ? 512'd2 : 512'd1);
                check_output("mode_cmd", 512'(core_mode_cmd), 512'(mdl_it.mode));
                check_output("block_hi", core_block_msg[1023:512], mdl_it.blk[1023:512]);
                check_output("block_lo", core_block_msg[511:0], mdl_it.blk[511:0]);
            end
            rdy_m          = 1'b0;
            busy_cnt       = 4;
            core_tag_valid = 1'b0;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                rdy_m          = 1'b1;
                core_tag_valid = 1'b1;
            end
        end
    end

    // Start a message and stream up to maxw of its words; called at a negedge.
    task automatic apply_stimulus(input int n, input bit md, input int maxw, output int base);
        int nwords, allw, k, stalls, fb_stalls;
        bit acc;
        for (int i = 0; i < 512; i++) msg[i] = 8'($urandom);
        if (n == 1) msg[0] = 8'h61;
        for (int i = 0; i < 16; i++) tag_in[32*i +: 32] = $urandom;
        push_expected(n, md);
        base  = blocks_seen;
        start = 1'b1;
        mode  = md;
        @(negedge clk);
        start = 1'b0;
        check_output("busy_after_start", 512'(busy), 512'd1);
        check_output("tag_valid_cleared", 512'(tag_valid), 512'd0);
        allw   = (n + 3) / 4;
        nwords = (maxw < allw) ? maxw : allw;
        k = 0; stalls = 0; fb_stalls = 0;
        while (k < nwords && stalls < 500) begin
            msg_valid      = 1'b1;
            msg_data       = {msg[4*k], msg[4*k+1], msg[4*k+2], msg[4*k+3]};
            msg_last       = (k == allw - 1);
            msg_last_bytes = msg_last ? 2'(n % 4) : 2'd0;
            start          = (k > 0);
            mode           = (k > 0) ? ~md : md;
            acc            = msg_ready;
            @(negedge clk);
            if (acc) begin
                if (k % 32 == 31) check_output("ready_low_after_word31", 512'(msg_ready), 512'd0);
                k++;
            end else begin
                stalls++;
                if (k < 32) fb_stalls++;
            end
        end
        msg_valid = 1'b0; msg_last = 1'b0; msg_last_bytes = 2'd0; start = 1'b0; mode = md;
        check_output("accepted_words", 512'(k), 512'(nwords));
        check_output("first_block_stalls", 512'(fb_stalls), 512'd0);
    endtask

    // Poke start while busy, wait for the tag and check the completed message.
    task automatic check_output_msg(input bit md, input int exp_blocks, input int base);
        int cyc = 0;
        start = 1'b1;
        mode  = ~md;
        repeat (2) begin
            @(negedge clk);
            check_output("busy_mid_msg", 512'(busy), 512'd1);
        end
        start = 1'b0;
        mode  = md;
        while (!tag_valid && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check_output("tag_valid_set", 512'(tag_valid), 512'd1);
        check_output("tag", tag, md ? tag_in : {tag_in[511:128], 128'd0});
        check_output("block_count", 512'(blocks_seen - base), 512'(exp_blocks));
        check_output("scoreboard_empty", 512'(exp_q.size()), 512'd0);
        @(negedge clk);
        check_output("tag_valid_sticky", 512'(tag_valid), 512'd1);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    // Main sequence.
    initial begin
        int base;
        int pulses;
        int blk_bad;
        vecs[0] = '{1,   1'b0, 1};
        vecs[1] = '{111, 1'b1, 1};
        vecs[2] = '{112, 1'b1, 2};
        vecs[3] = '{128, 1'b0, 2};
        vecs[4] = '{200, 1'b1, 2};
        vecs[5] = '{239, 1'b0, 2};
        vecs[6] = '{240, 1'b1, 3};
        vecs[7] = '{256, 1'b0, 3};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_output("reset_ctrl", 512'({msg_ready, busy, tag_valid, core_init_cmd, core_next_cmd, core_mode_cmd}), 512'd0);
        check_output("reset_tag", tag, 512'd0);
        check_output("reset_block_hi", core_block_msg[1023:512], 512'd0);
        check_output("reset_block_lo", core_block_msg[511:0], 512'd0);

        for (int v = 0; v < 8; v++) begin
            $display("[TB] message len=%0d mode=%0d", vecs[v].len, vecs[v].md);
            apply_stimulus(vecs[v].len, vecs[v].md, 64, base);
            check_output_msg(vecs[v].md, vecs[v].blocks, base);
        end

        $display("[TB] backpressure in ISSUE");
        hold = 1'b1;
        apply_stimulus(1, 1'b0, 64, base);
        pulses = 0;
        blk_bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (core_init_cmd || core_next_cmd) pulses++;
            if (exp_q.size() == 0 || core_block_msg !== exp_q[0].blk) blk_bad++;
        end
        check_output("no_pulse_in_hold", 512'(pulses), 512'd0);
        check_output("block_stable_in_hold", 512'(blk_bad), 512'd0);
        hold = 1'b0;
        @(negedge clk);
        check_output("pulse_after_release", 512'(core_init_cmd), 512'd1);
        check_output_msg(1'b0, 1, base);

        $display("[TB] zeroize after 10 words");
        apply_stimulus(100, 1'b1, 10, base);
        zeroize = 1'b1;
        @(negedge clk);
        check_output("zeroize_ctrl", 512'({msg_ready, busy, tag_valid, core_init_cmd, core_next_cmd, core_mode_cmd}), 512'd0);
        check_output("zeroize_tag", tag, 512'd0);
        check_output("zeroize_block_hi", core_block_msg[1023:512], 512'd0);
        check_output("zeroize_block_lo", core_block_msg[511:0], 512'd0);
        check_output("zeroize_no_cmds", 512'(blocks_seen - base), 512'd0);
        zeroize = 1'b0;
        exp_q.delete();
        @(negedge clk);
        apply_stimulus(1, 1'b0, 64, base);
        check_output_msg(1'b0, 1, base);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hmac_block_sequencer.md
# hmac_block_sequencer

Command-side initiator for the HMAC core. It accepts a byte-granular message as 32-bit big-endian words and packs them into 1024-bit blocks. It appends SHA-512 padding, including the length field that covers the inner key block, and drives the core's `init_cmd`/`next_cmd`/`block_msg` handshake one block per command. It captures the final tag and holds it for firmware and the key vault.

## Interface
Parameters: none. Block size, word size and length-field geometry are fixed constants in the package.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `zeroize`  in  1  synchronous clear; same effect as `reset`
- `start`  in  1  begin a new message; sampled in IDLE only
- `mode`  in  1  0 = HMAC384, 1 = HMAC512; latched on `start`
- `msg_valid`  in  1  message word valid
- `msg_ready`  out  1  sequencer accepts the word this cycle
- `msg_data`  in  32  message word; first byte in [31:24]
- `msg_last`  in  1  final word of the message
- `msg_last_bytes`  in  2  valid bytes in the last word; 0 means 4 bytes
- `core_init_cmd`  out  1  one-cycle pulse that issues the first block
- `core_next_cmd`  out  1  one-cycle pulse that issues each later block
- `core_mode_cmd`  out  1  latched `mode`
- `core_block_msg`  out  1024  current block; word 0 is in [1023:992]
- `core_ready`  in  1  core idle
- `core_tag_valid`  in  1  core tag valid
- `core_tag`  in  512  core tag
- `busy`  out  1  message in progress
- `tag_valid`  out  1  sticky; set when the tag is captured
- `tag`  out  512  captured tag; for HMAC384 only [511:128] is meaningful and [127:0] is forced to 0

## Operation
- **States:** IDLE, FILL, PADX (extra pad block), ISSUE, WAIT, DONE.
- **IDLE**
  - `start`: clear the block register, the word index `widx` (5 bit) and the byte count `nbytes` (64 bit); clear `tag_valid` and `tag`; latch `mode`; go to FILL.
  - `start` in any other state is ignored.
- **FILL**
  - `msg_ready` = 1.
  - A word is accepted when `msg_valid && msg_ready`. It is written to block word `widx`, `widx` increments, and `nbytes` adds 4, or `msg_last_bytes` for the last word.
  - Invalid lanes of the last word are zeroed.
- **Non-last word that fills word 31:** go to ISSUE with `final` = 0.
- **Last word:** let `off` = byte offset in the block after this word (1..128).
  - `off` ≤ 111: write 0x80 at byte `off` and write the length into bytes 112..127. Set `final` = 1 and go to ISSUE.
  - 112 ≤ `off` ≤ 127: write 0x80 at byte `off`. Set `final` = 0 and `padx_pending` = 1.
  - `off` = 128: set `final` = 0 and `padx_pending` = 1. Byte 0 of the next block gets 0x80.
- **Length field:** 128-bit big-endian value in bytes 112..127, equal to `1024 + 8*nbytes`. The top 64 bits are 0 and the arithmetic is 64-bit.
- **ISSUE**
  - Wait for `core_ready` = 1, then pulse `core_init_cmd` for the first block of the message, otherwise `core_next_cmd`, for exactly one cycle.
  - Go to WAIT.
- **WAIT**
  - Ignore `core_ready` in the first cycle after the pulse; the core drops it there.
  - Afterwards, on `core_ready` = 1:
    - `final`: capture `core_tag` (when `core_tag_valid` = 1) and go to DONE.
    - `padx_pending`: build the pad block, consisting of an optional 0x80 at byte 0, zeros, and the length. Clear `padx_pending`, set `final` = 1 and go to ISSUE. This is the PADX action.
    - Neither: clear the block and `widx`, then go to FILL.
- **DONE:** set `tag_valid` = 1 and go to IDLE.
- `core_block_msg` is stable from the ISSUE entry until the WAIT exit.
- Messages are at least 1 byte. A `msg_last` word outside FILL cannot be accepted.

## Timing
- **Reset values:** all outputs are 0, state = IDLE. `tag`, the block register and `nbytes` are cleared.
- **Reset or `zeroize` mid-message:** abort immediately, with no command pulse in that cycle.
- **Fill throughput:** one word per cycle, so a full block takes 32 cycles.
- **Full-block boundary:** `msg_ready` = 0 in the cycle after word 31 is accepted.
- **Issue latency:** the command pulse comes 1 cycle after ISSUE entry when `core_ready` is already high.
- **Tag latency:** `tag_valid` rises 2 cycles after WAIT sees `core_ready` with `final` set.
- **Simultaneous `msg_valid` and a full block:** there is no acceptance, because `msg_ready` is already low.

## Structure
- Package `hmac_seq_pkg` holds:
  - the state enum,
  - `BLOCK_WORDS` = 32,
  - `LEN_OFFSET` = 112,
  - `PAD_BYTE` = 8'h80,
  - `IPAD_BITS` = 1024.
- One sub-module is natural: `hmac_block_assembler`. It holds the 1024-bit block register and provides:
  - word write with lane masking,
  - pad-byte insert,
  - length insert,
  - clear.

## Test plan
- **1-byte message 0x61, HMAC384:** one `core_init_cmd`. Block = 0x6180…00 with the length field equal to 0x408. `core_mode_cmd` = 0. `tag_valid` = 1, and `tag`[127:0] = 0.
- **111-byte message:** one block. 0x80 at byte 111, length = 0x778.
- **112-byte message, HMAC512:**
  - `core_init_cmd`, then `core_next_cmd`.
  - Block 1: 0x80 at byte 112, length bytes zero.
  - Block 2: all zero except length = 0x780.
- **128-byte message:**
  - Block 1 is pure data.
  - Block 2 = 0x80 at byte 0 and length = 0x800.
  - 32 consecutive accepts, then `msg_ready` low.
- **Backpressure:** hold `core_ready` = 0 for 50 cycles in ISSUE. No pulse occurs and `core_block_msg` is unchanged. The pulse follows 1 cycle after `core_ready` rises.
- **`zeroize` after 10 words:** all outputs return to 0 and state = IDLE. A following 1-byte message completes correctly, and `start` during `busy` is ignored.
